// File: rtl/gray_updown_counter_fsm.sv
// Parametrised Moore up/down counter with enable, synchronous load,
// wrap/saturate mode, terminal-count flags, wrap pulse and Gray output.
//
// Optional feature macro: GRAY_OUT_EN
//   defined   -> gray_o = count_o ^ (count_o >> 1)
//   undefined -> gray_o tied to zero, no decode logic
//
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      synchronous active-low reset
//   en_i        step enable, one step per cycle
//   dir_i       1 = up, 0 = down
//   sat_mode_i  0 = wrap at bounds, 1 = saturate at bounds
//   load_i      synchronous load request (beats en_i)
//   load_val_i  load value, clamped to MAXVAL
//   count_o     current state, binary
//   gray_o      current state, Gray-coded
//   tc_up_o     count_o == MAXVAL
//   tc_down_o   count_o == 0
//   wrap_o      high for one cycle after a wrapping step
module gray_updown_counter_fsm #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned MAXVAL = (1 << WIDTH) - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             sat_mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             tc_up_o,
  output logic             tc_down_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAXVAL);

  typedef enum logic [1:0] {
    ActHold,
    ActLoad,
    ActStep
  } act_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  act_e             act;
  logic             at_max, at_zero, out_of_range;

  assign at_max       = (count_q == MaxCnt);
  assign at_zero      = (count_q == '0);
  assign out_of_range = (count_q > MaxCnt);

  always_comb begin
    act = ActHold;
    if (load_i) begin
      act = ActLoad;
    end else if (en_i) begin
      act = ActStep;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (act)
      ActLoad: begin
        count_d = (load_val_i > MaxCnt) ? MaxCnt : load_val_i;
      end
      ActStep: begin
        if (out_of_range) begin
          // Unreachable state: recover to a legal value.
          count_d = '0;
        end else if (dir_i) begin
          if (!at_max) begin
            count_d = count_q + WIDTH'(1);
          end else if (!sat_mode_i) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          if (!at_zero) begin
            count_d = count_q - WIDTH'(1);
          end else if (!sat_mode_i) begin
            count_d = MaxCnt;
            wrap_d  = 1'b1;
          end
        end
      end
      default: begin
        if (out_of_range) begin
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o   = count_q;
  assign tc_up_o   = at_max;
  assign tc_down_o = at_zero;
  assign wrap_o    = wrap_q;

`ifdef GRAY_OUT_EN
  assign gray_o = count_q ^ (count_q >> 1);
`else
  assign gray_o = '0;
`endif

endmodule

// File: tb/tb_gray_updown_counter_fsm.sv
// Randomised plus directed bench for gray_updown_counter_fsm. Two instances
// (MAXVAL = 7 and MAXVAL = 5, WIDTH = 3) share the same stimulus and are each
// compared every cycle against an arithmetic reference model.
module tb_gray_updown_counter_fsm;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, sat, load;
  logic [2:0] load_val;

  logic [2:0] cnt  [2];
  logic [2:0] gry  [2];
  logic       tcu  [2];
  logic       tcd  [2];
  logic       wrp  [2];

  int m_cnt  [2];
  int m_wrap [2];
  int maxv   [2];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gray_updown_counter_fsm #(.WIDTH(3), .MAXVAL(7)) u_dut7 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .dir_i      (dir),
    .sat_mode_i (sat),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (cnt[0]),
    .gray_o     (gry[0]),
    .tc_up_o    (tcu[0]),
    .tc_down_o  (tcd[0]),
    .wrap_o     (wrp[0])
  );

  gray_updown_counter_fsm #(.WIDTH(3), .MAXVAL(5)) u_dut5 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .dir_i      (dir),
    .sat_mode_i (sat),
    .load_i     (load),
    .load_val_i (load_val),
    .count_o    (cnt[1]),
    .gray_o     (gry[1]),
    .tc_up_o    (tcu[1]),
    .tc_down_o  (tcd[1]),
    .wrap_o     (wrp[1])
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: apply the priority rules reset > load > en > hold.
  task automatic model_step(input int i);
    int lv;
    lv = int'(load_val);
    if (!rst_n) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 0;
    end else if (load) begin
      m_cnt[i]  = (lv > maxv[i]) ? maxv[i] : lv;
      m_wrap[i] = 0;
    end else if (en) begin
      m_wrap[i] = 0;
      if (dir) begin
        if (m_cnt[i] < maxv[i]) m_cnt[i] = m_cnt[i] + 1;
        else if (!sat) begin m_cnt[i] = 0; m_wrap[i] = 1; end
      end else begin
        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        else if (!sat) begin m_cnt[i] = maxv[i]; m_wrap[i] = 1; end
      end
    end else begin
      m_wrap[i] = 0;
    end
  endtask

  task automatic check_all();
    int g;
    for (int i = 0; i < 2; i++) begin
`ifdef GRAY_OUT_EN
      g = m_cnt[i] ^ (m_cnt[i] / 2);
`else
      g = 0;
`endif
      check_eq($sformatf("count%0d", i),   int'(cnt[i]), m_cnt[i]);
      check_eq($sformatf("gray%0d", i),    int'(gry[i]), g);
      check_eq($sformatf("tc_up%0d", i),   int'(tcu[i]), (m_cnt[i] == maxv[i]) ? 1 : 0);
      check_eq($sformatf("tc_down%0d", i), int'(tcd[i]), (m_cnt[i] == 0) ? 1 : 0);
      check_eq($sformatf("wrap%0d", i),    int'(wrp[i]), m_wrap[i]);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic d, input logic s,
                       input logic l, input logic [2:0] lv);
    rst_n    = r;
    en       = e;
    dir      = d;
    sat      = s;
    load     = l;
    load_val = lv;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  initial begin
    maxv[0] = 7;
    maxv[1] = 5;
    m_cnt   = '{0, 0};
    m_wrap  = '{0, 0};
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; sat = 1'b0; load = 1'b0; load_val = '0;
    #2;

    // Reset dominates load and en.
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    // Up through the wrap.
    repeat (9) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    // Down into saturation, then one wrapping step.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    // Load beats en, value clamps; then wrap up.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    // Up saturation holds at the top.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    // Hold, mid-run reset, resume.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 24) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
